// File: rtl/video_cfg_pkg.sv
// video_cfg_pkg: shared field map, FSM encoding, mode-12 defaults and CTRL bit positions for video_cfg_bank
package video_cfg_pkg;
  localparam logic [3:0] F_RES_X    = 4'h0;
  localparam logic [3:0] F_HS_FP    = 4'h1;
  localparam logic [3:0] F_HS_WIDTH = 4'h2;
  localparam logic [3:0] F_HS_BP    = 4'h3;
  localparam logic [3:0] F_RES_Y    = 4'h4;
  localparam logic [3:0] F_VS_FP    = 4'h5;
  localparam logic [3:0] F_VS_WIDTH = 4'h6;
  localparam logic [3:0] F_VS_BP    = 4'h7;
  localparam logic [3:0] F_WPL      = 4'h9;
  localparam logic [3:0] F_MISC     = 4'hA;
  localparam logic [3:0] F_CTRL     = 4'hC;
  localparam logic [3:0] F_COUNT    = 4'hD;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_FLY, S_APPLY, S_REQ, S_ACKLO} state_t;
  localparam int DEF_RES_X    = 640;
  localparam int DEF_HS_FP    = 40;
  localparam int DEF_HS_WIDTH = 20;
  localparam int DEF_HS_BP    = 68;
  localparam int DEF_RES_Y    = 256;
  localparam int DEF_VS_FP    = 40;
  localparam int DEF_VS_WIDTH = 5;
  localparam int DEF_VS_BP    = 67;
  localparam int DEF_WPL_M1   = 79;
  localparam int DEF_BPP      = 2;
  localparam int DEF_CUR_X    = 217;
  localparam int C_COMMIT     = 0;
  localparam int C_TGT_LSB    = 4;
  localparam int C_AT_FLY     = 8;
  localparam int C_TREGS_ACK  = 9;
  localparam int C_ERR_CLR    = 10;
  localparam int C_ABORT      = 11;
endpackage

// File: rtl/video_cfg_bank_sync_ff2.sv
// sync_ff2: two-flop synchroniser; ports clk, reset_n (async active-low), d (async in), q (synchronised out)
module sync_ff2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/video_cfg_bank.sv
// video_cfg_bank: NUM_SETS shadow timing profiles plus one active profile with an atomic commit FSM
//   register bus: reg_addr/reg_wdata/reg_wstrobe in, reg_rdata out (combinational)
//   async inputs: sync_flybk, cfg_sync_ack (synchronised here); vidc_tregs_status in, vidc_tregs_ack out
//   handshake: cfg_sync_req out; active profile: act_* out, active_set, is_hires
module video_cfg_bank
  import video_cfg_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int TW       = 11,
  parameter int SW       = $clog2(NUM_SETS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [5+SW:0] reg_addr,
  input  logic [31:0]   reg_wdata,
  input  logic          reg_wstrobe,
  output logic [31:0]   reg_rdata,
  input  logic          sync_flybk,
  input  logic          cfg_sync_ack,
  input  logic          vidc_tregs_status,
  output logic          vidc_tregs_ack,
  output logic          cfg_sync_req,
  output logic [TW-1:0] act_res_x,
  output logic [TW-1:0] act_hs_fp,
  output logic [TW-1:0] act_hs_width,
  output logic [TW-1:0] act_hs_bp,
  output logic [TW-1:0] act_res_y,
  output logic [TW-1:0] act_vs_fp,
  output logic [TW-1:0] act_vs_width,
  output logic [TW-1:0] act_vs_bp,
  output logic [TW-1:0] act_cursor_x_offset,
  output logic [7:0]    act_wpl_m1,
  output logic [2:0]    act_bpp,
  output logic          act_hires,
  output logic          act_double_x,
  output logic          act_double_y,
  output logic          act_crtlook,
  output logic [SW-1:0] active_set,
  output logic          is_hires
);
  typedef struct packed {
    logic [TW-1:0] res_x, hs_fp, hs_width, hs_bp, res_y, vs_fp, vs_width, vs_bp, cur_x;
    logic [7:0]    wpl_m1;
    logic [2:0]    bpp;
    logic          hires, dbl_x, dbl_y, crtlook;
  } cfg_t;
  function automatic cfg_t cfg_default();
    cfg_t c = '0;
    c.res_x    = TW'(DEF_RES_X);
    c.hs_fp    = TW'(DEF_HS_FP);
    c.hs_width = TW'(DEF_HS_WIDTH);
    c.hs_bp    = TW'(DEF_HS_BP);
    c.res_y    = TW'(DEF_RES_Y);
    c.vs_fp    = TW'(DEF_VS_FP);
    c.vs_width = TW'(DEF_VS_WIDTH);
    c.vs_bp    = TW'(DEF_VS_BP);
    c.cur_x    = TW'(DEF_CUR_X);
    c.wpl_m1   = 8'(DEF_WPL_M1);
    c.bpp      = 3'(DEF_BPP);
    c.dbl_y    = 1'b1;
    return c;
  endfunction
  function automatic cfg_t cfg_write(cfg_t c, logic [3:0] f, logic [31:0] d);
    cfg_t r = c;
    case (f)
      F_RES_X:    begin r.res_x = d[TW-1:0]; r.dbl_x = d[31]; end
      F_HS_FP:    r.hs_fp = d[TW-1:0];
      F_HS_WIDTH: r.hs_width = d[TW-1:0];
      F_HS_BP:    r.hs_bp = d[TW-1:0];
      F_RES_Y:    begin r.res_y = d[TW-1:0]; r.crtlook = d[30]; r.dbl_y = d[31]; end
      F_VS_FP:    r.vs_fp = d[TW-1:0];
      F_VS_WIDTH: r.vs_width = d[TW-1:0];
      F_VS_BP:    r.vs_bp = d[TW-1:0];
      F_WPL:      r.wpl_m1 = d[7:0];
      F_MISC:     begin r.cur_x = d[TW-1:0]; r.bpp = d[30:28]; r.hires = d[31]; end
      default:    ;
    endcase
    return r;
  endfunction
  function automatic logic [31:0] cfg_read(cfg_t c, logic [3:0] f);
    logic [31:0] r = '0;
    case (f)
      F_RES_X:    begin r[TW-1:0] = c.res_x; r[31] = c.dbl_x; end
      F_HS_FP:    r[TW-1:0] = c.hs_fp;
      F_HS_WIDTH: r[TW-1:0] = c.hs_width;
      F_HS_BP:    r[TW-1:0] = c.hs_bp;
      F_RES_Y:    begin r[TW-1:0] = c.res_y; r[30] = c.crtlook; r[31] = c.dbl_y; end
      F_VS_FP:    r[TW-1:0] = c.vs_fp;
      F_VS_WIDTH: r[TW-1:0] = c.vs_width;
      F_VS_BP:    r[TW-1:0] = c.vs_bp;
      F_WPL:      r[7:0] = c.wpl_m1;
      F_MISC:     begin r[TW-1:0] = c.cur_x; r[30:28] = c.bpp; r[31] = c.hires; end
      default:    ;
    endcase
    return r;
  endfunction
  cfg_t          shadow [NUM_SETS];
  cfg_t          active;
  state_t        st, nxt;
  logic [SW-1:0] tgt;
  logic [15:0]   count;
  logic          err, flybk_s, flybk_d, ack_s;
  logic [3:0]    field;
  logic [SW-1:0] set_idx;
  logic          set_ok, tgt_ok, ctrl_wr, commit, abort, fly_edge, busy, shadow_wr;
  logic [31:0]   status;
  logic          unused;
  sync_ff2 u_fly (.clk(clk), .reset_n(reset_n), .d(sync_flybk), .q(flybk_s));
  sync_ff2 u_ack (.clk(clk), .reset_n(reset_n), .d(cfg_sync_ack), .q(ack_s));
  assign field     = reg_addr[5:2];
  assign set_idx   = reg_addr[5+SW:6];
  assign set_ok    = int'(set_idx) < NUM_SETS;
  assign tgt_ok    = int'(reg_wdata[C_TGT_LSB +: 4]) < NUM_SETS;
  assign ctrl_wr   = reg_wstrobe && field == F_CTRL;
  assign commit    = ctrl_wr && reg_wdata[C_COMMIT];
  assign abort     = ctrl_wr && reg_wdata[C_ABORT];
  assign shadow_wr = reg_wstrobe && field < F_CTRL && set_ok;
  assign fly_edge  = flybk_s && !flybk_d;
  assign busy      = st != S_IDLE;
  assign unused    = ^{reg_addr[1:0], reg_wdata[27:12]};
  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:     if (commit && tgt_ok) nxt = reg_wdata[C_AT_FLY] ? S_WAIT_FLY : S_APPLY;
      S_WAIT_FLY: nxt = abort ? S_IDLE : fly_edge ? S_APPLY : S_WAIT_FLY;
      S_APPLY:    nxt = S_REQ;
      S_REQ:      nxt = ack_s ? S_ACKLO : S_REQ;
      S_ACKLO:    nxt = ack_s ? S_ACKLO : S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st             <= S_IDLE;
      tgt            <= '0;
      count          <= '0;
      err            <= 1'b0;
      flybk_d        <= 1'b0;
      vidc_tregs_ack <= 1'b0;
      active         <= cfg_default();
      active_set     <= '0;
      for (int i = 0; i < NUM_SETS; i++) shadow[i] <= cfg_default();
    end else begin
      st      <= nxt;
      flybk_d <= flybk_s;
      if (ctrl_wr) vidc_tregs_ack <= reg_wdata[C_TREGS_ACK];
      if (ctrl_wr && reg_wdata[C_ERR_CLR]) err <= 1'b0;
      if (commit && (busy || !tgt_ok)) err <= 1'b1;
      if (commit && !busy && tgt_ok) tgt <= reg_wdata[C_TGT_LSB +: SW];
      // nonblocking read of shadow here means a same-cycle shadow write lands after the copy
      if (st == S_APPLY) begin
        active     <= shadow[tgt];
        active_set <= tgt;
        count      <= count + 16'd1;
      end
      if (shadow_wr) shadow[set_idx] <= cfg_write(shadow[set_idx], field, reg_wdata);
    end
  assign status = {16'h0, err, st, 2'b00, 4'(active_set), flybk_s, vidc_tregs_status,
                   vidc_tregs_ack, ack_s, busy, 1'b0};
  assign reg_rdata = field == F_CTRL ? status :
                     field == F_COUNT ? {16'h0, count} :
                     (field < F_CTRL && set_ok) ? cfg_read(shadow[set_idx], field) : 32'h0;
  assign cfg_sync_req        = st == S_REQ;
  assign act_res_x           = active.res_x;
  assign act_hs_fp           = active.hs_fp;
  assign act_hs_width        = active.hs_width;
  assign act_hs_bp           = active.hs_bp;
  assign act_res_y           = active.res_y;
  assign act_vs_fp           = active.vs_fp;
  assign act_vs_width        = active.vs_width;
  assign act_vs_bp           = active.vs_bp;
  assign act_cursor_x_offset = active.cur_x;
  assign act_wpl_m1          = active.wpl_m1;
  assign act_bpp             = active.bpp;
  assign act_hires           = active.hires;
  assign act_double_x        = active.dbl_x;
  assign act_double_y        = active.dbl_y;
  assign act_crtlook         = active.crtlook;
  assign is_hires            = active.hires;
endmodule

// File: tb/tb_video_cfg_bank.sv
// tb_video_cfg_bank: randomized self-checking bench for video_cfg_bank against a register-map level model
module tb_video_cfg_bank;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_wstrobe = 1'b0;
  logic [31:0] reg_rdata;
  logic        sync_flybk = 1'b0, cfg_sync_ack = 1'b0, vidc_tregs_status = 1'b0;
  logic        vidc_tregs_ack, cfg_sync_req;
  logic [10:0] act_res_x, act_hs_fp, act_hs_width, act_hs_bp, act_res_y;
  logic [10:0] act_vs_fp, act_vs_width, act_vs_bp, act_cursor_x_offset;
  logic [7:0]  act_wpl_m1;
  logic [2:0]  act_bpp;
  logic        act_hires, act_double_x, act_double_y, act_crtlook, is_hires;
  logic [1:0]  active_set;

  video_cfg_bank #(.NUM_SETS(4), .TW(11)) dut (
    .clk(clk), .reset_n(reset_n), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wstrobe(reg_wstrobe), .reg_rdata(reg_rdata), .sync_flybk(sync_flybk),
    .cfg_sync_ack(cfg_sync_ack), .vidc_tregs_status(vidc_tregs_status),
    .vidc_tregs_ack(vidc_tregs_ack), .cfg_sync_req(cfg_sync_req),
    .act_res_x(act_res_x), .act_hs_fp(act_hs_fp), .act_hs_width(act_hs_width),
    .act_hs_bp(act_hs_bp), .act_res_y(act_res_y), .act_vs_fp(act_vs_fp),
    .act_vs_width(act_vs_width), .act_vs_bp(act_vs_bp),
    .act_cursor_x_offset(act_cursor_x_offset), .act_wpl_m1(act_wpl_m1), .act_bpp(act_bpp),
    .act_hires(act_hires), .act_double_x(act_double_x), .act_double_y(act_double_y),
    .act_crtlook(act_crtlook), .active_set(active_set), .is_hires(is_hires)
  );

  always #5 clk = ~clk;

  localparam int ST_IDLE = 0, ST_WAIT = 1, ST_REQ = 3;

  int          vectors = 0, miscompares = 0;
  logic [31:0] m_sh [4][12];
  logic [31:0] m_act [12];
  int          m_set, m_count;
  logic        m_err, m_tack;

  function automatic logic [31:0] fmask(int w);
    case (w)
      0:                fmask = 32'h8000_07FF;
      1, 2, 3, 5, 6, 7: fmask = 32'h0000_07FF;
      4:                fmask = 32'hC000_07FF;
      9:                fmask = 32'h0000_00FF;
      10:               fmask = 32'hF000_07FF;
      default:          fmask = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fdef(int w);
    case (w)
      0:       fdef = 32'd640;
      1:       fdef = 32'd40;
      2:       fdef = 32'd20;
      3:       fdef = 32'd68;
      4:       fdef = 32'h8000_0100;
      5:       fdef = 32'd40;
      6:       fdef = 32'd5;
      7:       fdef = 32'd67;
      9:       fdef = 32'd79;
      10:      fdef = 32'h2000_00D9;
      default: fdef = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] act_word(int w);
    logic [31:0] r = '0;
    case (w)
      0:  begin r[10:0] = act_res_x; r[31] = act_double_x; end
      1:  r[10:0] = act_hs_fp;
      2:  r[10:0] = act_hs_width;
      3:  r[10:0] = act_hs_bp;
      4:  begin r[10:0] = act_res_y; r[30] = act_crtlook; r[31] = act_double_y; end
      5:  r[10:0] = act_vs_fp;
      6:  r[10:0] = act_vs_width;
      7:  r[10:0] = act_vs_bp;
      9:  r[7:0] = act_wpl_m1;
      10: begin r[10:0] = act_cursor_x_offset; r[30:28] = act_bpp; r[31] = act_hires; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_status(int st);
    return {16'h0, m_err, 3'(st), 2'b00, 4'(m_set), sync_flybk, vidc_tregs_status,
            m_tack, cfg_sync_ack, st != 0, 1'b0};
  endfunction

  function automatic logic [7:0] ctrl_addr();
    return {2'($urandom), 6'h30};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) for (int w = 0; w < 12; w++) m_sh[s][w] = fdef(w);
    for (int w = 0; w < 12; w++) m_act[w] = fdef(w);
    m_set = 0; m_count = 0; m_err = 1'b0; m_tack = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wstrobe = 1'b1;
    @(negedge clk);
    reg_wstrobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_addr = a;
    #1 d = reg_rdata;
    @(negedge clk);
  endtask

  task automatic sh_wr(input int s, input int w, input logic [31:0] d);
    wr({2'(s), 4'(w), 2'($urandom)}, d);
    m_sh[s][w] = d & fmask(w);
  endtask

  task automatic ctrl(input logic [31:0] d);
    wr(ctrl_addr(), d);
    m_tack = d[9];
    if (d[10]) m_err = 1'b0;
  endtask

  task automatic do_ack(output int c1, output int c2);
    logic [31:0] d;
    cfg_sync_ack = 1'b1;
    c1 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!cfg_sync_req) begin c1 = i; break; end
    end
    cfg_sync_ack = 1'b0;
    c2 = -1;
    for (int i = 0; i < 20; i++) begin
      rd(ctrl_addr(), d);
      if (!d[1]) begin c2 = i; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int s, w;
    for (int k = 0; k < 11; k++) if (k != 8) begin
      vectors++;
      if (act_word(k) !== m_act[k]) begin
        miscompares++; $display("FAIL reset_act w%0d: got %h expected %h", k, act_word(k), m_act[k]);
      end
    end
    vectors++;
    if (active_set !== 2'd0) begin miscompares++; $display("FAIL reset_set: got %0d expected 0", active_set); end
    vectors++;
    if (cfg_sync_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", cfg_sync_req); end
    vectors++;
    if (vidc_tregs_ack !== 1'b0) begin miscompares++; $display("FAIL reset_tack: got %b expected 0", vidc_tregs_ack); end
    vectors++;
    if (is_hires !== m_act[10][31]) begin miscompares++; $display("FAIL reset_hires: got %b expected %b", is_hires, m_act[10][31]); end
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL reset_status: got %h expected %h", d, exp_status(ST_IDLE)); end
    rd({2'($urandom), 6'h34}, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_count: got %h expected 0", d); end
    repeat (8) begin
      s = $urandom % 4; w = $urandom % 12;
      rd({2'(s), 4'(w), 2'b00}, d);
      vectors++;
      if (d !== m_sh[s][w]) begin miscompares++; $display("FAIL reset_shadow s%0d w%0d: got %h expected %h", s, w, d, m_sh[s][w]); end
    end
  endtask

  task automatic test_shadow_rw();
    logic [31:0] d;
    int s, w;
    repeat (40) sh_wr($urandom % 4, $urandom % 12, $urandom);
    repeat (30) begin
      s = $urandom % 4; w = $urandom % 12;
      rd({2'(s), 4'(w), 2'($urandom)}, d);
      vectors++;
      if (d !== m_sh[s][w]) begin miscompares++; $display("FAIL shadow_rd s%0d w%0d: got %h expected %h", s, w, d, m_sh[s][w]); end
    end
    for (int k = 0; k < 11; k++) if (k != 8) begin
      vectors++;
      if (act_word(k) !== m_act[k]) begin
        miscompares++; $display("FAIL shadow_act_stable w%0d: got %h expected %h", k, act_word(k), m_act[k]);
      end
    end
  endtask

  task automatic test_immediate();
    logic [31:0] d;
    int c1, c2;
    wr(8'h80, 32'd800);
    m_sh[2][0] = 32'd800;
    ctrl(32'h21);
    vectors++;
    if (act_word(0) !== m_act[0]) begin miscompares++; $display("FAIL imm_n1_act: got %h expected %h", act_word(0), m_act[0]); end
    vectors++;
    if (cfg_sync_req !== 1'b0) begin miscompares++; $display("FAIL imm_n1_req: got %b expected 0", cfg_sync_req); end
    @(negedge clk);
    m_act = m_sh[2]; m_set = 2; m_count++;
    vectors++;
    if (act_res_x !== 11'd800) begin miscompares++; $display("FAIL imm_res_x: got %0d expected 800", act_res_x); end
    for (int k = 0; k < 11; k++) if (k != 8) begin
      vectors++;
      if (act_word(k) !== m_act[k]) begin
        miscompares++; $display("FAIL imm_act w%0d: got %h expected %h", k, act_word(k), m_act[k]);
      end
    end
    vectors++;
    if (active_set !== 2'd2) begin miscompares++; $display("FAIL imm_set: got %0d expected 2", active_set); end
    vectors++;
    if (cfg_sync_req !== 1'b1) begin miscompares++; $display("FAIL imm_req: got %b expected 1", cfg_sync_req); end
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_REQ)) begin miscompares++; $display("FAIL imm_status: got %h expected %h", d, exp_status(ST_REQ)); end
    rd({2'($urandom), 6'h34}, d);
    vectors++;
    if (d !== 32'(m_count)) begin miscompares++; $display("FAIL imm_count: got %0d expected %0d", d, m_count); end
    repeat (5) @(negedge clk);
    vectors++;
    if (cfg_sync_req !== 1'b1) begin miscompares++; $display("FAIL imm_req_hold: got %b expected 1", cfg_sync_req); end
    do_ack(c1, c2);
    vectors++;
    if (c1 < 2 || c1 > 4) begin miscompares++; $display("FAIL imm_req_drop: got %0d cycles expected 2..4", c1); end
    vectors++;
    if (c2 < 1 || c2 > 5) begin miscompares++; $display("FAIL imm_idle: got %0d cycles expected 1..5", c2); end
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL imm_status_idle: got %h expected %h", d, exp_status(ST_IDLE)); end
  endtask

  task automatic test_random_commits();
    logic [31:0] d;
    logic [31:0] cw;
    int t, c1, c2;
    repeat (6) begin
      t = $urandom % 4;
      repeat (3) sh_wr(t, $urandom % 12, $urandom);
      cw = 32'h1 | (32'(t) << 4) | (32'($urandom % 2) << 9);
      ctrl(cw);
      for (int k = 0; k < 11; k++) if (k != 8) begin
        vectors++;
        if (act_word(k) !== m_act[k]) begin
          miscompares++; $display("FAIL rnd_early w%0d: got %h expected %h", k, act_word(k), m_act[k]);
        end
      end
      @(negedge clk);
      m_act = m_sh[t]; m_set = t; m_count++;
      for (int k = 0; k < 11; k++) if (k != 8) begin
        vectors++;
        if (act_word(k) !== m_act[k]) begin
          miscompares++; $display("FAIL rnd_act t%0d w%0d: got %h expected %h", t, k, act_word(k), m_act[k]);
        end
      end
      vectors++;
      if (int'(active_set) !== m_set) begin miscompares++; $display("FAIL rnd_set: got %0d expected %0d", active_set, m_set); end
      vectors++;
      if (vidc_tregs_ack !== m_tack) begin miscompares++; $display("FAIL rnd_tack: got %b expected %b", vidc_tregs_ack, m_tack); end
      vectors++;
      if (is_hires !== m_act[10][31]) begin miscompares++; $display("FAIL rnd_hires: got %b expected %b", is_hires, m_act[10][31]); end
      do_ack(c1, c2);
      vectors++;
      if (c1 < 2 || c1 > 4) begin miscompares++; $display("FAIL rnd_req_drop: got %0d expected 2..4", c1); end
    end
    rd({2'($urandom), 6'h34}, d);
    vectors++;
    if (d !== 32'(m_count)) begin miscompares++; $display("FAIL rnd_count: got %0d expected %0d", d, m_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, nv;
    int t, c1, c2;
    t = $urandom % 4;
    nv = $urandom;
    reg_addr = ctrl_addr(); reg_wdata = 32'h1 | (32'(t) << 4); reg_wstrobe = 1'b1;
    m_tack = 1'b0;
    @(negedge clk);
    reg_addr = {2'(t), 4'h0, 2'b00}; reg_wdata = nv;
    @(negedge clk);
    reg_wstrobe = 1'b0;
    m_act = m_sh[t]; m_set = t; m_count++;
    m_sh[t][0] = nv & fmask(0);
    for (int k = 0; k < 11; k++) if (k != 8) begin
      vectors++;
      if (act_word(k) !== m_act[k]) begin
        miscompares++; $display("FAIL b2b_act w%0d: got %h expected %h", k, act_word(k), m_act[k]);
      end
    end
    rd({2'(t), 4'h0, 2'b00}, d);
    vectors++;
    if (d !== m_sh[t][0]) begin miscompares++; $display("FAIL b2b_shadow: got %h expected %h", d, m_sh[t][0]); end
    do_ack(c1, c2);
    vectors++;
    if (c1 < 2 || c1 > 4) begin miscompares++; $display("FAIL b2b_req_drop: got %0d expected 2..4", c1); end
  endtask

  task automatic test_flyback();
    logic [31:0] d;
    int t, k, c1, c2;
    t = (m_set + 1 + int'($urandom % 3)) % 4;
    sh_wr(t, 0, {1'b0, 20'h0, 11'($urandom)} ^ {21'h0, 11'(m_act[0][10:0])} ^ 32'h1);
    ctrl(32'h101 | (32'(t) << 4));
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (int'(active_set) !== m_set || act_word(0) !== m_act[0]) begin
        miscompares++; $display("FAIL fly_hold c%0d: got set %0d res %h expected set %0d res %h", i, active_set, act_word(0), m_set, m_act[0]);
      end
    end
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_WAIT)) begin miscompares++; $display("FAIL fly_status: got %h expected %h", d, exp_status(ST_WAIT)); end
    sh_wr(t, 4, $urandom);
    sync_flybk = 1'b1;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (int'(active_set) == t) begin k = i; break; end
    end
    vectors++;
    if (k < 3 || k > 5) begin miscompares++; $display("FAIL fly_latency: got %0d expected 3..5", k); end
    m_act = m_sh[t]; m_set = t; m_count++;
    for (int w = 0; w < 11; w++) if (w != 8) begin
      vectors++;
      if (act_word(w) !== m_act[w]) begin
        miscompares++; $display("FAIL fly_act w%0d: got %h expected %h", w, act_word(w), m_act[w]);
      end
    end
    do_ack(c1, c2);
    vectors++;
    if (c2 < 1 || c2 > 5) begin miscompares++; $display("FAIL fly_idle: got %0d expected 1..5", c2); end
    sync_flybk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    int t;
    t = (m_set + 1 + int'($urandom % 3)) % 4;
    sh_wr(t, 0, m_act[0] ^ 32'h3);
    ctrl(32'h101 | (32'(t) << 4));
    repeat (3) @(negedge clk);
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_WAIT)) begin miscompares++; $display("FAIL abort_wait: got %h expected %h", d, exp_status(ST_WAIT)); end
    sync_flybk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ctrl(32'h800);
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL abort_status: got %h expected %h", d, exp_status(ST_IDLE)); end
    repeat (5) @(negedge clk);
    for (int w = 0; w < 11; w++) if (w != 8) begin
      vectors++;
      if (act_word(w) !== m_act[w]) begin
        miscompares++; $display("FAIL abort_act w%0d: got %h expected %h", w, act_word(w), m_act[w]);
      end
    end
    vectors++;
    if (int'(active_set) !== m_set) begin miscompares++; $display("FAIL abort_set: got %0d expected %0d", active_set, m_set); end
    rd({2'($urandom), 6'h34}, d);
    vectors++;
    if (d !== 32'(m_count)) begin miscompares++; $display("FAIL abort_count: got %0d expected %0d", d, m_count); end
    sync_flybk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] d;
    int t, c1, c2;
    ctrl(32'h51);
    m_err = 1'b1;
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL err_bad_tgt: got %h expected %h", d, exp_status(ST_IDLE)); end
    ctrl(32'h400);
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL err_clear: got %h expected %h", d, exp_status(ST_IDLE)); end
    ctrl(32'h1 | (32'(4 + $urandom % 12) << 4));
    m_err = 1'b1;
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL err_bad_tgt2: got %h expected %h", d, exp_status(ST_IDLE)); end
    ctrl(32'h400);
    t = $urandom % 4;
    ctrl(32'h1 | (32'(t) << 4));
    @(negedge clk);
    m_act = m_sh[t]; m_set = t; m_count++;
    ctrl(32'h1 | (32'((t + 1) % 4) << 4));
    m_err = 1'b1;
    ctrl(32'h800);
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_REQ)) begin miscompares++; $display("FAIL err_busy: got %h expected %h", d, exp_status(ST_REQ)); end
    vectors++;
    if (int'(active_set) !== m_set) begin miscompares++; $display("FAIL err_busy_set: got %0d expected %0d", active_set, m_set); end
    do_ack(c1, c2);
    vectors++;
    if (c1 < 2 || c1 > 4) begin miscompares++; $display("FAIL err_req_drop: got %0d expected 2..4", c1); end
    rd({2'($urandom), 6'h34}, d);
    vectors++;
    if (d !== 32'(m_count)) begin miscompares++; $display("FAIL err_count: got %0d expected %0d", d, m_count); end
    ctrl(32'h400);
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL err_clear2: got %h expected %h", d, exp_status(ST_IDLE)); end
  endtask

  task automatic test_tregs();
    logic [31:0] d;
    repeat (4) begin
      vidc_tregs_status = 1'($urandom);
      ctrl(32'($urandom % 2) << 9);
      vectors++;
      if (vidc_tregs_ack !== m_tack) begin miscompares++; $display("FAIL tregs_ack: got %b expected %b", vidc_tregs_ack, m_tack); end
      rd(ctrl_addr(), d);
      vectors++;
      if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL tregs_status: got %h expected %h", d, exp_status(ST_IDLE)); end
    end
    vidc_tregs_status = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int t;
    t = (m_set + 1) % 4;
    sh_wr(t, 0, 32'h0000_0123);
    ctrl(32'h1 | (32'(t) << 4));
    @(negedge clk);
    vectors++;
    if (cfg_sync_req !== 1'b1) begin miscompares++; $display("FAIL rst_mid_req_pre: got %b expected 1", cfg_sync_req); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (cfg_sync_req !== 1'b0) begin miscompares++; $display("FAIL rst_mid_req: got %b expected 0", cfg_sync_req); end
    vectors++;
    if (active_set !== 2'd0) begin miscompares++; $display("FAIL rst_mid_set: got %0d expected 0", active_set); end
    for (int w = 0; w < 11; w++) if (w != 8) begin
      vectors++;
      if (act_word(w) !== m_act[w]) begin
        miscompares++; $display("FAIL rst_mid_act w%0d: got %h expected %h", w, act_word(w), m_act[w]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd({2'(t), 4'h0, 2'b00}, d);
    vectors++;
    if (d !== m_sh[t][0]) begin miscompares++; $display("FAIL rst_mid_shadow: got %h expected %h", d, m_sh[t][0]); end
    rd(ctrl_addr(), d);
    vectors++;
    if (d !== exp_status(ST_IDLE)) begin miscompares++; $display("FAIL rst_mid_status: got %h expected %h", d, exp_status(ST_IDLE)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_shadow_rw();
    test_immediate();
    test_random_commits();
    test_back_to_back();
    test_flyback();
    test_abort();
    test_errors();
    test_tregs();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
